ip_rx_sequencer: RTL and testbench
==================================

IP_RX_SEQUENCER -- requirements
Module: ip_rx_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles a header stage may stay active without its done pulse.
REQ-002 Parameter CNT_W, default 16: width of each statistics counter.
REQ-003 aclk  input  1  single clock; all logic is on its rising edge.
REQ-004 aresetn  input  1  asynchronous, active-low reset.
REQ-005 data_valid  input  1  frame byte strobe from the MAC; high across the whole frame, low between frames.
REQ-006 eth_hdr_done / eth_type_ip  input  1 each  one-cycle done pulse from the Ethernet header parser; eth_type_ip is qualified by that pulse.
REQ-007 ip_header_done / ip_header_valid  input  1 each  from the IP header parser; valid arrives exactly 1 cycle after done, or not at all.
REQ-008 udp_hdr_done / udp_hdr_valid  input  1 each  one-cycle pulses from the UDP header parser.
REQ-009 ip_parse_en  output  1  enables the IP header parser (its eth_type_ip_valid input).
REQ-010 udp_parse_en  output  1  enables the UDP header parser.
REQ-011 payload_en  output  1  gates payload bytes to the user.
REQ-012 frame_accept / frame_drop  output  1 each  one-cycle end-of-frame result pulses.
REQ-013 stat_rx, stat_acc, stat_drop, stat_tmo  output  CNT_W each  frame statistics (only when the feature in REQ-030 is compiled in).

Function
REQ-014 FSM states: IDLE, ETH_HDR, IP_HDR, IP_CHK, UDP_HDR, PAYLOAD, DROP.
REQ-015 IDLE -> ETH_HDR on data_valid rising (previous cycle low, current high).
REQ-016 ETH_HDR -> IP_HDR on eth_hdr_done with eth_type_ip=1; -> DROP on eth_hdr_done with eth_type_ip=0.
REQ-017 IP_HDR -> IP_CHK on ip_header_done.
REQ-018 IP_CHK lasts exactly 1 cycle: -> UDP_HDR if ip_header_valid=1, else -> DROP.
REQ-019 UDP_HDR -> PAYLOAD on udp_hdr_done with udp_hdr_valid=1; -> DROP on udp_hdr_done with udp_hdr_valid=0.
REQ-020 Outputs are registered Moore decodes: ip_parse_en=1 in IP_HDR; udp_parse_en=1 in UDP_HDR; payload_en=1 in PAYLOAD; all three are 0 in every other state.
REQ-021 Stage watchdog: an 8-bit-or-wider cycle counter clears on every state change and increments in ETH_HDR, IP_HDR and UDP_HDR; on reaching TIMEOUT_CYCLES-1 the FSM -> DROP and the frame counts as a timeout.
REQ-022 data_valid falling while in PAYLOAD: one-cycle frame_accept pulse, then -> IDLE.
REQ-023 data_valid falling in any other non-IDLE state: one-cycle frame_drop pulse, then -> IDLE.
REQ-024 DROP holds until data_valid falls, then pulses frame_drop and goes to IDLE; frame_drop pulses once per frame.
REQ-025 If data_valid falls in the same cycle as a done pulse, the frame-end handling (REQ-022/023) takes priority over the done pulse.
REQ-026 After a frame end, the next frame starts only on a new data_valid rising edge.
REQ-027 frame_accept and frame_drop are never high in the same cycle.

Reset
REQ-028 Reset forces: FSM=IDLE; watchdog=0; all enables and pulse outputs=0; all stat counters=0.
REQ-029 Reset asserted mid-frame abandons the frame with no result pulse; after release, the sequencer waits for a fresh data_valid rising edge.

Configuration
REQ-030 Macro IP_RX_SEQ_STATS_EN controls the statistics counters.
REQ-031 With the macro defined: stat_rx increments on each frame start, stat_acc on each frame_accept, stat_drop on each frame_drop, and stat_tmo on each watchdog expiry; all counters saturate at all-ones.
REQ-032 Without the macro: the stat outputs and their logic are absent.

Structure
REQ-033 The shared package eth_pkg holds the FSM state enum and the header-length constants ETH_HDR_LEN=14, IP_HDR_LEN=20, UDP_HDR_LEN=8.
REQ-034 A saturating counter is one sub-module, sat_counter, instantiated four times under the macro.

Verification
REQ-035 Good frame (type 0x0800, IP valid, UDP valid, 30 payload bytes) -> payload_en high for the payload; one frame_accept; stat_acc=1.
REQ-036 Ethertype 0x0806 -> DROP; ip_parse_en never asserts; one frame_drop at data_valid fall.
REQ-037 ip_header_done followed by ip_header_valid=0 -> IP_CHK -> DROP; udp_parse_en never asserts.
REQ-038 No udp_hdr_done within 64 cycles -> DROP at cycle 64; stat_tmo=1; exactly one frame_drop.
REQ-039 data_valid falls in the same cycle as udp_hdr_done -> frame_drop, no frame_accept; next frame is accepted normally.
REQ-040 aresetn low in PAYLOAD -> all outputs 0 immediately; no result pulse; stat counters=0.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the IP receive path: sequencer state encoding and header lengths.
// Header lengths are in bytes (one byte per data_valid cycle).
package eth_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ETH_HDR = 3'd1,
    S_IP_HDR  = 3'd2,
    S_IP_CHK  = 3'd3,
    S_UDP_HDR = 3'd4,
    S_PAYLOAD = 3'd5,
    S_DROP    = 3'd6
  } rx_state_e;

  localparam int ETH_HDR_LEN = 14;
  localparam int IP_HDR_LEN  = 20;
  localparam int UDP_HDR_LEN = 8;

  // Stages that wait on an external parser and are therefore watchdog-guarded.
  function automatic logic is_hdr_stage(rx_state_e s);
    return (s == S_ETH_HDR) || (s == S_IP_HDR) || (s == S_UDP_HDR);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc_i pulses, holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ip_rx_sequencer.sv
// Frame sequencer for the Eth/IP/UDP receive path with per-stage watchdog and end-of-frame result pulses.
// Optional statistics counters are compiled in with IP_RX_SEQ_STATS_EN.
module ip_rx_sequencer
  import eth_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             data_valid,
  input  logic             eth_hdr_done,
  input  logic             eth_type_ip,
  input  logic             ip_header_done,
  input  logic             ip_header_valid,
  input  logic             udp_hdr_done,
  input  logic             udp_hdr_valid,
  output logic             ip_parse_en,
  output logic             udp_parse_en,
  output logic             payload_en,
  output logic             frame_accept,
  output logic             frame_drop
`ifdef IP_RX_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_rx,
  output logic [CNT_W-1:0] stat_acc,
  output logic [CNT_W-1:0] stat_drop,
  output logic [CNT_W-1:0] stat_tmo
`endif
);

  localparam int WD_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

  if (TIMEOUT_CYCLES < 2 || CNT_W < 1) begin : g_cfg_err
    $error("ip_rx_sequencer: TIMEOUT_CYCLES must be >= 2 and CNT_W >= 1");
  end

  rx_state_e       state_q, state_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            dv_q;
  logic            dv_rise, dv_fall, wd_hit, tmo_evt;
  logic            accept_d, drop_d;
  logic            ip_en_q, udp_en_q, pay_en_q, accept_q, drop_q;

  assign dv_rise = data_valid & ~dv_q;
  assign dv_fall = ~data_valid & dv_q;
  assign wd_hit  = is_hdr_stage(state_q) && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Frame end outranks any done pulse in the same cycle; a done pulse outranks the watchdog.
  always_comb begin
    state_d  = state_q;
    accept_d = 1'b0;
    drop_d   = 1'b0;
    tmo_evt  = 1'b0;
    if (state_q == S_IDLE) begin
      if (dv_rise) state_d = S_ETH_HDR;
    end else if (dv_fall) begin
      state_d  = S_IDLE;
      accept_d = (state_q == S_PAYLOAD);
      drop_d   = (state_q != S_PAYLOAD);
    end else begin
      case (state_q)
        S_ETH_HDR: begin
          if (eth_hdr_done) state_d = eth_type_ip ? S_IP_HDR : S_DROP;
          else              tmo_evt = wd_hit;
        end
        S_IP_HDR: begin
          if (ip_header_done) state_d = S_IP_CHK;
          else                tmo_evt = wd_hit;
        end
        S_IP_CHK:  state_d = ip_header_valid ? S_UDP_HDR : S_DROP;
        S_UDP_HDR: begin
          if (udp_hdr_done) state_d = udp_hdr_valid ? S_PAYLOAD : S_DROP;
          else              tmo_evt = wd_hit;
        end
        default: ;
      endcase
      if (tmo_evt) state_d = S_DROP;
    end
  end

  always_comb begin
    wdog_d = '0;
    if (state_d == state_q && is_hdr_stage(state_q)) wdog_d = wdog_q + WD_W'(1);
  end

  // dv_q resets high so a frame already in flight at reset release is not mistaken for a new start.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      wdog_q   <= '0;
      dv_q     <= 1'b1;
      ip_en_q  <= 1'b0;
      udp_en_q <= 1'b0;
      pay_en_q <= 1'b0;
      accept_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wdog_q   <= wdog_d;
      dv_q     <= data_valid;
      ip_en_q  <= (state_d == S_IP_HDR);
      udp_en_q <= (state_d == S_UDP_HDR);
      pay_en_q <= (state_d == S_PAYLOAD);
      accept_q <= accept_d;
      drop_q   <= drop_d;
    end
  end

  assign ip_parse_en  = ip_en_q;
  assign udp_parse_en = udp_en_q;
  assign payload_en   = pay_en_q;
  assign frame_accept = accept_q;
  assign frame_drop   = drop_q;

`ifdef IP_RX_SEQ_STATS_EN
  logic frame_start;
  assign frame_start = (state_q == S_IDLE) && dv_rise;

  sat_counter #(.W(CNT_W)) u_stat_rx   (.clk_i(aclk), .rst_ni(aresetn), .inc_i(frame_start), .cnt_o(stat_rx));
  sat_counter #(.W(CNT_W)) u_stat_acc  (.clk_i(aclk), .rst_ni(aresetn), .inc_i(accept_d),    .cnt_o(stat_acc));
  sat_counter #(.W(CNT_W)) u_stat_drop (.clk_i(aclk), .rst_ni(aresetn), .inc_i(drop_d),      .cnt_o(stat_drop));
  sat_counter #(.W(CNT_W)) u_stat_tmo  (.clk_i(aclk), .rst_ni(aresetn), .inc_i(tmo_evt),     .cnt_o(stat_tmo));
`endif

endmodule

// File: tb/tb_ip_rx_sequencer.sv
// Bench for ip_rx_sequencer: directed scenarios plus randomized frames against a timeline model.
// Statistics checks are active when IP_RX_SEQ_STATS_EN is defined.
module tb_ip_rx_sequencer;

  localparam int T  = 64;
  localparam int CW = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic data_valid = 1'b0, eth_hdr_done = 1'b0, eth_type_ip = 1'b0;
  logic ip_header_done = 1'b0, ip_header_valid = 1'b0;
  logic udp_hdr_done = 1'b0, udp_hdr_valid = 1'b0;
  logic ip_parse_en, udp_parse_en, payload_en, frame_accept, frame_drop;
`ifdef IP_RX_SEQ_STATS_EN
  logic [CW-1:0] stat_rx, stat_acc, stat_drop, stat_tmo;
`endif

  int checks = 0;
  int failures = 0;
  int exp_rx = 0, exp_acc = 0, exp_drop = 0, exp_tmo = 0;

  always #5 aclk = ~aclk;

  ip_rx_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .data_valid      (data_valid),
    .eth_hdr_done    (eth_hdr_done),
    .eth_type_ip     (eth_type_ip),
    .ip_header_done  (ip_header_done),
    .ip_header_valid (ip_header_valid),
    .udp_hdr_done    (udp_hdr_done),
    .udp_hdr_valid   (udp_hdr_valid),
    .ip_parse_en     (ip_parse_en),
    .udp_parse_en    (udp_parse_en),
    .payload_en      (payload_en),
    .frame_accept    (frame_accept),
    .frame_drop      (frame_drop)
`ifdef IP_RX_SEQ_STATS_EN
    ,
    .stat_rx         (stat_rx),
    .stat_acc        (stat_acc),
    .stat_drop       (stat_drop),
    .stat_tmo        (stat_tmo)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_idle();
    data_valid = 0; eth_hdr_done = 0; eth_type_ip = 0;
    ip_header_done = 0; ip_header_valid = 0; udp_hdr_done = 0; udp_hdr_valid = 0;
  endtask

  task automatic chk_stats(input string tag);
`ifdef IP_RX_SEQ_STATS_EN
    chk({tag, ".st_rx"},   stat_rx,   exp_rx);
    chk({tag, ".st_acc"},  stat_acc,  exp_acc);
    chk({tag, ".st_drop"}, stat_drop, exp_drop);
    chk({tag, ".st_tmo"},  stat_tmo,  exp_tmo);
`endif
  endtask

  // Timeline model. Frame cycle 0 is the first data_valid-high cycle, data_valid low from cycle L.
  // A stage entered at cycle t waits for its done pulse until cycle t+T-1 (then times out);
  // a pulse at or after cycle L loses to the frame end, and the result pulse lands at cycle L+1.
  task automatic model(input int L, input int E, input bit et, input int I, input bit iv,
                       input int U, input bit uv, output bit acc, output bit tmo,
                       output int ipc, output int udpc, output int payc);
    int t, lim;
    acc = 0; tmo = 0; ipc = 0; udpc = 0; payc = 0;
    t = 1; lim = t + T - 1;
    if (!(E < L && E <= lim)) begin tmo = (lim < L); return; end
    if (!et) return;
    t = E + 1; lim = t + T - 1;
    if (!(I < L && I <= lim)) begin
      tmo = (lim < L); ipc = (tmo ? lim : L) - t + 1; return;
    end
    ipc = I - t + 1;
    if (I + 1 >= L || !iv) return;
    t = I + 2; lim = t + T - 1;
    if (!(U < L && U <= lim)) begin
      tmo = (lim < L); udpc = (tmo ? lim : L) - t + 1; return;
    end
    udpc = U - t + 1;
    if (!uv) return;
    payc = L - U; acc = 1;
  endtask

  task automatic run_frame(input int L, input int E, input bit et, input int I, input bit iv,
                           input int U, input bit uv, input int gap, input string tag);
    bit m_acc, m_tmo;
    int m_ipc, m_udpc, m_payc;
    int ipn = 0, udpn = 0, payn = 0, accn = 0, dropn = 0, both = 0, pcyc = -1;
    model(L, E, et, I, iv, U, uv, m_acc, m_tmo, m_ipc, m_udpc, m_payc);
    for (int c = 0; c < L + gap; c++) begin
      tick();
      ipn  += int'(ip_parse_en);
      udpn += int'(udp_parse_en);
      payn += int'(payload_en);
      if (frame_accept) begin accn++; pcyc = c; end
      if (frame_drop)   begin dropn++; pcyc = c; end
      if (frame_accept && frame_drop) both++;
      data_valid      = (c < L);
      eth_hdr_done    = (c == E) && (c <= L);
      eth_type_ip     = (c == E) ? et : 1'($urandom_range(0, 1));
      ip_header_done  = (c == I) && (c <= L);
      ip_header_valid = (c == I + 1) && (c <= L) && iv;
      udp_hdr_done    = (c == U) && (c <= L);
      udp_hdr_valid   = (c == U) ? uv : 1'($urandom_range(0, 1));
    end
    drive_idle();
    exp_rx++;
    if (m_acc) exp_acc++; else exp_drop++;
    if (m_tmo) exp_tmo++;
    chk({tag, ".accept"}, accn, int'(m_acc));
    chk({tag, ".drop"},   dropn, int'(!m_acc));
    chk({tag, ".both"},   both, 0);
    chk({tag, ".pcyc"},   pcyc, L + 1);
    chk({tag, ".ip_en"},  ipn, m_ipc);
    chk({tag, ".udp_en"}, udpn, m_udpc);
    chk({tag, ".pay_en"}, payn, m_payc);
    chk_stats(tag);
  endtask

  int e0, i0, u0;
  int cnt_any;

  initial begin
    e0 = eth_pkg::ETH_HDR_LEN;
    i0 = e0 + eth_pkg::IP_HDR_LEN;
    u0 = i0 + 2 + eth_pkg::UDP_HDR_LEN;

    drive_idle();
    repeat (3) tick();
    chk("rst.ip_en",  ip_parse_en, 0);
    chk("rst.udp_en", udp_parse_en, 0);
    chk("rst.pay_en", payload_en, 0);
    chk("rst.accept", frame_accept, 0);
    chk("rst.drop",   frame_drop, 0);
    chk_stats("rst");
    aresetn = 1;
    repeat (3) tick();

    run_frame(u0 + 30, e0, 1, i0, 1, u0, 1, 4, "good");
    run_frame(u0 + 30, e0, 0, i0, 1, u0, 1, 4, "arp");
    run_frame(u0 + 30, e0, 1, i0, 0, u0, 1, 4, "ipbad");
    run_frame(u0 + 30, e0, 1, i0, 1, u0, 0, 4, "udpbad");
    run_frame(u0 + 100, e0, 1, i0, 1, 100000, 1, 4, "udptmo");
    run_frame(100, 100000, 1, 100000, 1, 100000, 1, 4, "ethtmo");
    run_frame(u0, e0, 1, i0, 1, u0, 1, 4, "fallx");
    run_frame(u0 + 5, e0, 1, i0, 1, u0, 1, 4, "good2");
    run_frame(1, 5, 1, 8, 1, 12, 1, 3, "short");

    // Reset asserted while in PAYLOAD.
    for (int c = 0; c <= u0 + 5; c++) begin
      tick();
      data_valid      = 1;
      eth_hdr_done    = (c == e0);
      eth_type_ip     = (c == e0);
      ip_header_done  = (c == i0);
      ip_header_valid = (c == i0 + 1);
      udp_hdr_done    = (c == u0);
      udp_hdr_valid   = (c == u0);
    end
    tick();
    chk("rstp.pre_pay", payload_en, 1);
    #2 aresetn = 0;
    #1;
    exp_rx = 0; exp_acc = 0; exp_drop = 0; exp_tmo = 0;
    chk("rstp.pay_en", payload_en, 0);
    chk("rstp.accept", frame_accept, 0);
    chk("rstp.drop",   frame_drop, 0);
    chk_stats("rstp");
    eth_hdr_done = 0; eth_type_ip = 0; ip_header_done = 0;
    ip_header_valid = 0; udp_hdr_done = 0; udp_hdr_valid = 0;
    repeat (2) tick();
    aresetn = 1;
    cnt_any = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      cnt_any += int'(ip_parse_en) + int'(udp_parse_en) + int'(payload_en)
               + int'(frame_accept) + int'(frame_drop);
      data_valid = (c < 6);
    end
    chk("rstp.quiet", cnt_any, 0);
    chk_stats("rstp.post");
    run_frame(u0 + 10, e0, 1, i0, 1, u0, 1, 4, "after_rst");

    for (int f = 0; f < 30; f++) begin
      int fe, fi, fu, fl;
      bit fet, fiv, fuv;
      fe  = 1 + $urandom_range(0, 20);
      if ($urandom_range(0, 7) == 0) fe += 55;
      fet = ($urandom_range(0, 5) != 0);
      fi  = fe + 1 + $urandom_range(0, 25);
      if ($urandom_range(0, 7) == 0) fi += 55;
      fiv = ($urandom_range(0, 5) != 0);
      fu  = fi + 2 + $urandom_range(0, 10);
      if ($urandom_range(0, 7) == 0) fu += 60;
      fuv = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 2) == 0) fl = $urandom_range(1, fu + 2);
      else                           fl = fu + $urandom_range(1, 40);
      run_frame(fl, fe, fet, fi, fiv, fu, fuv, 2 + $urandom_range(1, 4), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
